seq_divider: RTL

//  Multi-cycle restoring divider: inverse of the team's combinational W x W multiplier. Takes a
//  2W-bit dividend (product-width) and a W-bit divisor; returns W-bit quotient and remainder.
//  One quotient bit per clock; start/busy/done handshake; results held until the next start.

---
 rtl/div_pkg.sv | 5 +
 rtl/div_step.sv | 19 +
 rtl/seq_divider.sv | 83 ++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam int DIV_W_DEFAULT = 4;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, shift {rem,quo} left and subtract b when it fits
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] b,
  output logic [W:0]   rem_n,
  output logic [W-1:0] quo_n
);
  logic [W+1:0] sh;
  logic         ge;
  always_comb begin
    sh    = {rem, quo[W-1]};
    ge    = sh >= {2'b00, b};
    rem_n = ge ? (W+1)'(sh - {2'b00, b}) : sh[W:0];
    quo_n = {quo[W-2:0], ge};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, 2W/W -> W quotient and remainder; DIV_DBZ_PORT_EN adds dbz output
module seq_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] p,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf
`ifdef DIV_DBZ_PORT_EN
  ,output logic          dbz
`endif
);
  localparam int CW = $clog2(W + 1);
  div_state_t   state;
  logic [W:0]   rem, rem_n;
  logic [W-1:0] quo, quo_n, bl;
  logic [CW-1:0] cnt;
  div_step #(.W(W)) u_step (.rem(rem), .quo(quo), .b(bl), .rem_n(rem_n), .quo_n(quo_n));
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      ovf   <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      bl    <= '0;
      cnt   <= '0;
`ifdef DIV_DBZ_PORT_EN
      dbz   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (b != '0 && p[2*W-1:W] < b) begin
            state <= RUN;
            rem   <= {1'b0, p[2*W-1:W]};
            quo   <= p[W-1:0];
            bl    <= b;
            cnt   <= '0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            ovf   <= 1'b1;
            q     <= '1;
            r     <= '0;
`ifdef DIV_DBZ_PORT_EN
            dbz   <= b == '0;
`endif
          end
        end
        RUN: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            q     <= quo_n;
            r     <= rem_n[W-1:0];
            ovf   <= 1'b0;
`ifdef DIV_DBZ_PORT_EN
            dbz   <= 1'b0;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
